// File: rtl/alu_ctrl_pkg.sv
// Shared FSM state encoding, select code constants and counter-width helper for the ALU bus sequencer.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam int SEL_NONE  = 0;
  localparam int WS_RESULT = 1;
  localparam int WS_FLAGS  = 2;

  // Width of a down-counter that must hold max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/alu_bus_seq_if.sv
// Micro-op command handshake from the sequencer plus the registered load/drive strobes back to the datapath.
interface alu_bus_seq_if #(
  parameter int NUM_SRC = 3,
  parameter int NUM_DST = 2
);
  localparam int RS_W = $clog2(NUM_SRC + 1);
  localparam int WS_W = $clog2(NUM_DST + 1);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [RS_W-1:0]    cmd_rs;
  logic [WS_W-1:0]    cmd_ws;
  logic [NUM_SRC-1:0] rd_en;
  logic [NUM_DST-1:0] wr_en;
  logic               busy;
  logic               err;

  modport master (
    output cmd_valid, cmd_rs, cmd_ws,
    input  cmd_ready, rd_en, wr_en, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_rs, cmd_ws,
    output cmd_ready, rd_en, wr_en, busy, err
  );
endinterface

// File: rtl/alu_sel_dec.sv
// Select code to one-hot decoder; code 0 gives all-zero, codes above N raise err.
// Latency: combinational.
// Backpressure: none, pure decode.
module alu_sel_dec #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [W-1:0] sel,
  output logic [N-1:0] onehot,
  output logic         err
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = (int'(sel) == i + 1);
    end
  end

  assign err = (int'(sel) > N);

endmodule

// File: rtl/alu_bus_seq.sv
// Sequences ALU operand loads and bus drives, enforcing an operand-to-result settle time.
// Latency: strobes registered, one cycle after acceptance (drives may wait ALU_LAT cycles).
// Backpressure: cmd_ready only in IDLE; a drive command blocks intake until its drive window ends.
module alu_bus_seq
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int NUM_DST = 2,
  parameter int ALU_LAT = 2,
  parameter int DRV_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_bus_seq_if.slave bus
);

  localparam int RS_W  = $clog2(NUM_SRC + 1);
  localparam int WS_W  = $clog2(NUM_DST + 1);
  localparam int LAT_W = cnt_w(ALU_LAT);
  localparam int DRV_W = cnt_w(DRV_CYC - 1);
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(ALU_LAT);
  localparam logic [DRV_W-1:0] DRV_INIT   = DRV_W'(DRV_CYC - 1);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [DRV_W-1:0]   drv_q, drv_d;
  logic [NUM_SRC-1:0] rd_hold_q, rd_hold_d;
  logic [NUM_DST-1:0] wr_hold_q, wr_hold_d;
  logic [NUM_SRC-1:0] rd_en_q, rd_en_d;
  logic [NUM_DST-1:0] wr_en_q, wr_en_d;
  logic               err_q, err_d;

  logic [NUM_SRC-1:0] rs_oh;
  logic [NUM_DST-1:0] ws_oh;
  logic               rs_bad, ws_bad;

  alu_sel_dec #(.N(NUM_SRC), .W(RS_W)) u_rs_dec (
    .sel    (bus.cmd_rs),
    .onehot (rs_oh),
    .err    (rs_bad)
  );

  alu_sel_dec #(.N(NUM_DST), .W(WS_W)) u_ws_dec (
    .sel    (bus.cmd_ws),
    .onehot (ws_oh),
    .err    (ws_bad)
  );

  always_comb begin
    state_d   = state_q;
    lat_d     = (lat_q != '0) ? lat_q - LAT_W'(1) : lat_q;
    drv_d     = drv_q;
    rd_hold_d = rd_hold_q;
    wr_hold_d = wr_hold_q;
    rd_en_d   = '0;
    wr_en_d   = '0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (rs_bad || ws_bad) begin
            err_d = 1'b1;
          end else if (bus.cmd_ws == WS_W'(SEL_NONE)) begin
            if (bus.cmd_rs != RS_W'(SEL_NONE)) begin
              rd_en_d = rs_oh;
              lat_d   = LAT_RELOAD;
            end
          end else begin
            rd_hold_d = rs_oh;
            wr_hold_d = ws_oh;
            // lat_q is sampled before this edge's decrement, so 1 still blocks.
            if (lat_q == '0) begin
              state_d = DRIVE;
              wr_en_d = ws_oh;
              drv_d   = DRV_INIT;
              if (DRV_CYC == 1) rd_en_d = rs_oh;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = DRIVE;
          wr_en_d = wr_hold_q;
          drv_d   = DRV_INIT;
          if (DRV_CYC == 1) rd_en_d = rd_hold_q;
        end
      end
      DRIVE: begin
        if (drv_q == '0) begin
          state_d   = IDLE;
          rd_hold_d = '0;
          wr_hold_d = '0;
          if (rd_hold_q != '0) lat_d = LAT_RELOAD;
        end else begin
          wr_en_d = wr_hold_q;
          drv_d   = drv_q - DRV_W'(1);
          // Operand capture lands in the last drive cycle, when the bus is stable.
          if (drv_q == DRV_W'(1)) rd_en_d = rd_hold_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      drv_q     <= '0;
      rd_hold_q <= '0;
      wr_hold_q <= '0;
      rd_en_q   <= '0;
      wr_en_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      drv_q     <= drv_d;
      rd_hold_q <= rd_hold_d;
      wr_hold_q <= wr_hold_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      err_q     <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE) || (lat_q != '0);
  assign bus.rd_en     = rd_en_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_bus_seq.sv
// Bench for alu_bus_seq: per-cycle vector table on the default build, hand sequences on two variants.
module tb_alu_bus_seq;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // u0: defaults; u1: no settle time with a long drive; u2: two operand registers
  alu_bus_seq_if #(.NUM_SRC(3), .NUM_DST(2)) bus0 ();
  alu_bus_seq_if #(.NUM_SRC(3), .NUM_DST(2)) bus1 ();
  alu_bus_seq_if #(.NUM_SRC(2), .NUM_DST(2)) bus2 ();

  alu_bus_seq #(.NUM_SRC(3), .NUM_DST(2), .ALU_LAT(2), .DRV_CYC(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  alu_bus_seq #(.NUM_SRC(3), .NUM_DST(2), .ALU_LAT(0), .DRV_CYC(3)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  alu_bus_seq #(.NUM_SRC(2), .NUM_DST(2), .ALU_LAT(2), .DRV_CYC(1)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  typedef struct {
    logic       v;
    logic [1:0] rs;
    logic [1:0] ws;
    logic [2:0] rd;
    logic [1:0] wr;
    logic       err;
    logic       rdy;
    logic       busy;
  } vec_t;

  vec_t       vq[$];
  logic [5:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic v, input int rs, input int ws, input int rd, input int wr,
                     input logic err, input logic rdy, input logic busy);
    vec_t t;
    t.v = v; t.rs = 2'(rs); t.ws = 2'(ws); t.rd = 3'(rd); t.wr = 2'(wr);
    t.err = err; t.rdy = rdy; t.busy = busy;
    vq.push_back(t);
  endtask

  task automatic drive1(input logic v, input int rs, input int ws);
    bus1.cmd_valid = v; bus1.cmd_rs = 2'(rs); bus1.cmd_ws = 2'(ws);
  endtask

  // Strobe scoreboard on u0: every nonzero strobe cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && ({bus0.rd_en, bus0.wr_en, bus0.err} != 6'd0)) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got rd=%b wr=%b err=%b expected no strobe",
                 bus0.rd_en, bus0.wr_en, bus0.err);
      end else begin
        check("sb_strobe", 32'({bus0.rd_en, bus0.wr_en, bus0.err}), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    bus0.cmd_valid = 1'b0; bus0.cmd_rs = '0; bus0.cmd_ws = '0;
    bus1.cmd_valid = 1'b0; bus1.cmd_rs = '0; bus1.cmd_ws = '0;
    bus2.cmd_valid = 1'b0; bus2.cmd_rs = '0; bus2.cmd_ws = '0;

    // Reset values, both during and after reset
    #3;
    check("rst_rdy", 32'(bus0.cmd_ready), 1);
    check("rst_wr", 32'(bus0.wr_en), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check("idle_rd", 32'(bus0.rd_en), 0);
    check("idle_wr", 32'(bus0.wr_en), 0);
    check("idle_err", 32'(bus0.err), 0);
    check("idle_rdy", 32'(bus0.cmd_ready), 1);
    check("idle_busy", 32'(bus0.busy), 0);
    check("idle_busy_u1", 32'(bus1.busy), 0);

    //   v  rs ws         rd     wr   err  rdy busy
    add(1, 1, 0,         3'b001, 0,   0,   1,  1);   // back-to-back loads
    add(1, 2, 0,         3'b010, 0,   0,   1,  1);
    add(1, 3, 0,         3'b100, 0,   0,   1,  1);
    add(0, 0, 0,         0,      0,   0,   1,  1);
    add(0, 0, 0,         0,      0,   0,   1,  0);
    add(1, 1, 0,         3'b001, 0,   0,   1,  1);   // load then drive waits
    add(1, 0, WS_RESULT, 0,      0,   0,   0,  1);
    add(1, 2, 0,         0,      0,   0,   0,  1);   // offered while busy: ignored
    add(0, 0, 0,         0,      1,   0,   0,  1);
    add(0, 0, 0,         0,      0,   0,   1,  0);
    add(1, 3, WS_FLAGS,  3'b100, 2,   0,   0,  1);   // move, single drive cycle
    add(0, 0, 0,         0,      0,   0,   1,  1);
    add(1, 0, WS_RESULT, 0,      0,   0,   0,  1);   // blocked by the move's reload
    add(0, 0, 0,         0,      0,   0,   0,  1);
    add(0, 0, 0,         0,      1,   0,   0,  1);
    add(0, 0, 0,         0,      0,   0,   1,  0);
    add(1, 1, 3,         0,      0,   1,   1,  0);   // ws out of range
    add(1, 0, 0,         0,      0,   0,   1,  0);   // NOP
    add(1, 2, WS_RESULT, 3'b010, 1,   0,   0,  1);
    add(0, 0, 0,         0,      0,   0,   1,  1);
    add(0, 0, 0,         0,      0,   0,   1,  1);
    add(0, 0, 0,         0,      0,   0,   1,  0);
    add(1, 1, 0,         3'b001, 0,   0,   1,  1);   // drive with one settle cycle left
    add(0, 0, 0,         0,      0,   0,   1,  1);
    add(1, 0, WS_FLAGS,  0,      0,   0,   0,  1);
    add(0, 0, 0,         0,      2,   0,   0,  1);
    add(0, 0, 0,         0,      0,   0,   1,  0);

    for (int i = 0; i < vq.size(); i++) begin
      bus0.cmd_valid = vq[i].v;
      bus0.cmd_rs    = vq[i].rs;
      bus0.cmd_ws    = vq[i].ws;
      if ({vq[i].rd, vq[i].wr, vq[i].err} != 6'd0) sb_q.push_back({vq[i].rd, vq[i].wr, vq[i].err});
      @(negedge clk);
      check($sformatf("row%0d_rdy", i), 32'(bus0.cmd_ready), 32'(vq[i].rdy));
      check($sformatf("row%0d_busy", i), 32'(bus0.busy), 32'(vq[i].busy));
    end
    bus0.cmd_valid = 1'b0;
    @(negedge clk); #1;
    check("sb_drain", 32'(sb_q.size()), 0);

    // Three-cycle drive with move; operand load only in the final cycle
    begin
      logic [1:0] exp_wr[4];
      logic [2:0] exp_rd[4];
      logic       exp_rdy[4];
      exp_wr  = '{2'b10, 2'b10, 2'b10, 2'b00};
      exp_rd  = '{3'b000, 3'b000, 3'b010, 3'b000};
      exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
      drive1(1, 2, WS_FLAGS);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        drive1(0, 0, 0);
        check($sformatf("lng%0d_wr", c), 32'(bus1.wr_en), 32'(exp_wr[c]));
        check($sformatf("lng%0d_rd", c), 32'(bus1.rd_en), 32'(exp_rd[c]));
        check($sformatf("lng%0d_rdy", c), 32'(bus1.cmd_ready), 32'(exp_rdy[c]));
      end
      check("lng_busy_after", 32'(bus1.busy), 0);
    end

    // Zero settle time: a drive right after a load is not held back
    drive1(1, 1, 0);
    @(negedge clk);
    check("z_load_rd", 32'(bus1.rd_en), 3'b001);
    check("z_load_busy", 32'(bus1.busy), 0);
    drive1(1, 0, WS_RESULT);
    @(negedge clk);
    drive1(0, 0, 0);
    check("z_drive_wr", 32'(bus1.wr_en), 2'b01);
    repeat (3) @(negedge clk);
    check("z_done_rdy", 32'(bus1.cmd_ready), 1);

    // rs above NUM_SRC on the two-register build
    bus2.cmd_valid = 1'b1; bus2.cmd_rs = 2'd3; bus2.cmd_ws = 2'd0;
    @(negedge clk);
    bus2.cmd_valid = 1'b0;
    check("oor_err", 32'(bus2.err), 1);
    check("oor_rd", 32'(bus2.rd_en), 0);
    check("oor_rdy", 32'(bus2.cmd_ready), 1);
    bus2.cmd_valid = 1'b1; bus2.cmd_rs = 2'd2;
    @(negedge clk);
    bus2.cmd_valid = 1'b0; bus2.cmd_rs = 2'd0;
    check("oor_err_clr", 32'(bus2.err), 0);
    check("oor_next_rd", 32'(bus2.rd_en), 2'b10);

    // Asynchronous reset in the middle of a drive window
    drive1(1, 1, WS_FLAGS);
    @(negedge clk);
    drive1(0, 0, 0);
    check("mid_wr", 32'(bus1.wr_en), 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wr", 32'(bus1.wr_en), 0);
    check("arst_rdy", 32'(bus1.cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post%0d_strb", c), 32'({bus1.rd_en, bus1.wr_en}), 0);
      check($sformatf("post%0d_rdy", c), 32'(bus1.cmd_ready), 1);
    end
    check("post_busy", 32'(bus1.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_bus_seq.md
Name: alu_bus_seq

Overview:
Parametrised sequential successor to the ALU register-control decoder. It accepts micro-op commands (operand load select and bus drive select) over a valid/ready handshake and issues registered one-hot load and drive strobes. It enforces an ALU settle latency after every operand load before result or flags may be driven. It holds the drive enable for a configurable number of bus cycles. It sits between the microcode sequencer and the ALU operand, result and flag registers.

Parameters:
NUM_SRC, 3, number of operand registers loadable from BUS (rs codes 1..NUM_SRC; 0 = none)
NUM_DST, 2, number of ALU sources drivable onto BUS (ws codes 1..NUM_DST; 1 = result, 2 = flags; 0 = none)
ALU_LAT, 2, cycles the result/flags need to settle after an operand load (>=0)
DRV_CYC, 1, cycles wr_en is held per drive command (>=1)
RS_W, $clog2(NUM_SRC+1), rs select width (derived)
WS_W, $clog2(NUM_DST+1), ws select width (derived)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when valid && ready
cmd_rs  input  RS_W  read select (BUS -> operand register)
cmd_ws  input  WS_W  write select (ALU source -> BUS)
rd_en  output  NUM_SRC  one-hot operand load strobe, registered
wr_en  output  NUM_DST  one-hot bus drive enable, registered
busy  output  1  state != IDLE or lat_cnt != 0
err  output  1  one-cycle pulse: out-of-range select

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset (async, rst_n=0): state=IDLE, rd_en=0, wr_en=0, err=0, lat_cnt=0, held command cleared. Resulting outputs: cmd_ready=1, busy=0. Reset mid-operation drops the in-flight command. No strobe is issued after release.
- cmd_ready = (state==IDLE). Purely state-based; it never depends on cmd_valid or the payload.
- States: IDLE, WAIT, DRIVE.
- IDLE, command accepted at edge T:
  - rs > NUM_SRC or ws > NUM_DST: err=1 for the cycle after T. No strobes, state stays IDLE.
  - rs=0, ws=0 (NOP): no strobes, stays IDLE.
  - rs!=0, ws=0: rd_en[rs-1]=1 for exactly one cycle after T. lat_cnt <= ALU_LAT at T. Stays IDLE, so back-to-back loads are possible every cycle.
  - ws!=0 and lat_cnt==0 at T (after the same-edge decrement would reach 0 counts as nonzero): state <= DRIVE, wr_en[ws-1]=1 from T.
  - ws!=0 and lat_cnt!=0: state <= WAIT. The command is held.
- WAIT: lat_cnt decrements each edge. At the first edge where lat_cnt==0 is sampled: state <= DRIVE, wr_en asserted from that edge.
- DRIVE: wr_en held for exactly DRV_CYC cycles, then state <= IDLE and wr_en <= 0 on the same edge.
  - If the held rs!=0 (move: source -> BUS -> operand), rd_en[rs-1] pulses in the final DRIVE cycle only. lat_cnt <= ALU_LAT at the edge leaving DRIVE.
- lat_cnt: saturating down-counter, width $clog2(ALU_LAT+1) (min 1). A reload has priority over a decrement. With ALU_LAT=0 it never blocks.
- Invariants: rd_en and wr_en are each one-hot or zero; at most one command is in flight; err never coincides with any strobe from the same command.

Decomposition:
- Package alu_ctrl_pkg: state enum (IDLE, WAIT, DRIVE), SEL_NONE=0, WS_RESULT=1, WS_FLAGS=2.
- Sub-module alu_sel_dec #(N): select code -> N-bit one-hot plus range-error flag. Instantiated twice, for rs and ws.
- The top module holds the FSM, lat_cnt, drive counter and output registers.

Test Plan:
1. Defaults; rst_n=0 then release, no commands -> rd_en=000, wr_en=00, err=0, cmd_ready=1, busy=0.
2. Back-to-back rs=1,2,3 with ws=0 on consecutive cycles -> rd_en=001,010,100 on consecutive cycles; cmd_ready stays 1; busy stays 1 until 2 cycles after the last load.
3. rs=1 accepted at edge T, then ws=1 at T+1 -> WAIT; wr_en=01 asserted from edge T+3 for 1 cycle; cmd_ready=0 over T+1..T+3; IDLE at T+4.
4. DRV_CYC=3, ALU_LAT=0, command rs=2, ws=2 -> wr_en=10 for 3 cycles; rd_en=010 only in the 3rd cycle; lat_cnt stays 0.
5. rs=3, ws=0 with NUM_SRC=2 (RS_W=2) -> err pulses 1 cycle; rd_en=0; state IDLE; next valid command is accepted normally.
6. rst_n dropped mid-DRIVE -> wr_en=0 immediately (async); after release, no strobe and cmd_ready=1.
